// File: rtl/fdiv_dispatch_pkg.sv
// fdiv_dispatch_pkg: float32 field positions, default tag type and operand sanitizer
package fdiv_dispatch_pkg;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MANT_MSB = 22;
  localparam int TAG_W = 5;
  typedef logic [TAG_W-1:0] tag_t;
  function automatic logic [31:0] sanitize(input logic [31:0] x);
    logic [EXP_MSB-EXP_LSB:0] e;
    e = x[EXP_MSB:EXP_LSB];
    return (&e || ~|e) ? {x[31:EXP_LSB], {(MANT_MSB+1){1'b0}}} : x;
  endfunction
endpackage

// File: rtl/fdiv_result_fifo.sv
// fdiv_result_fifo: circular result buffer; a push into a full FIFO is legal when the head pops in the same cycle
module fdiv_result_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 37
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr, rd;
  always_comb begin
    rd = pop && cnt_q != '0;
    wr = push && (cnt_q != CW'(DEPTH) || rd);
    wp_d = clr ? '0 : wp_q + AW'(wr);
    rp_d = clr ? '0 : rp_q + AW'(rd);
    cnt_d = clr ? '0 : cnt_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !clr) mem_q[wp_q] <= din;
  end
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/fdiv_dispatch.sv
// fdiv_dispatch: feeds a fixed-latency, non-stalling fdiv pipeline and buffers its results;
// credit (inflight + queued < DEPTH) guarantees every result has a FIFO slot.
module fdiv_dispatch
  import fdiv_dispatch_pkg::*;
#(
  parameter int NSTAGE = 6,
  parameter int TAGW = $bits(tag_t),
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_x2,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     fdiv_x1,
  output logic [31:0]     fdiv_x2,
  input  logic [31:0]     fdiv_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_y,
  output logic [TAGW-1:0] rsp_tag,
  output logic            busy
);
  localparam int IW = $clog2(NSTAGE+1);
  localparam int CW = $clog2(DEPTH+1);
  logic en_q;
  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [NSTAGE-1:0][TAGW-1:0] tag_q, tag_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [31:0] x1_q, x1_d, x2_q, x2_d;
  logic [CW-1:0] count;
  logic [TAGW+31:0] head;
  logic acc, push, pop;
  always_comb begin
    acc = req_valid && req_ready;
    vld_d = flush ? '0 : {vld_q[NSTAGE-2:0], acc};
    tag_d = {tag_q[NSTAGE-2:0], req_tag};
    inflight_d = flush ? '0 : inflight_q + IW'(acc) - IW'(vld_q[NSTAGE-1]);
    x1_d = acc ? sanitize(req_x1) : x1_q;
    x2_d = acc ? sanitize(req_x2) : x2_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_q <= 1'b0;
      vld_q <= '0;
      tag_q <= '0;
      inflight_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
    end else begin
      en_q <= 1'b1;
      vld_q <= vld_d;
      tag_q <= tag_d;
      inflight_q <= inflight_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end
  // pops in the same cycle are not credited back, so a push can never meet a full FIFO
  assign req_ready = en_q && !flush && (int'(inflight_q) + int'(count) < DEPTH);
  assign push = vld_q[NSTAGE-1] && !flush;
  assign pop = rsp_valid && rsp_ready && !flush;
  fdiv_result_fifo #(.DEPTH(DEPTH), .W(TAGW+32)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .clr(flush),
    .push(push),
    .din({tag_q[NSTAGE-1], fdiv_y}),
    .pop(pop),
    .dout(head),
    .count(count)
  );
  assign fdiv_x1 = x1_q;
  assign fdiv_x2 = x2_q;
  assign rsp_valid = count != '0;
  assign rsp_y = rsp_valid ? head[31:0] : '0;
  assign rsp_tag = rsp_valid ? head[TAGW+31:32] : '0;
  assign busy = inflight_q != '0 || count != '0;
endmodule
